// File: rtl/ppu_sprite_pkg.sv
// ---------------------------------------------------------------------------
// ppu_sprite_pkg
//
// Shared definitions for the sprite pixel path: attribute-byte bit positions,
// the packed pixel type handed to the compositor, the upper bound on the
// number of sprite slots, and a byte mirror used for horizontal flipping.
//
// No ports (package).
// ---------------------------------------------------------------------------
package ppu_sprite_pkg;

    // Upper bound on the number of sprite slots a bank may be built with.
    localparam int MAX_SPRITES = 64;

    // Bit positions inside the OAM attribute byte.
    localparam int ATTR_PAL_LO = 0;
    localparam int ATTR_PRI    = 5;
    localparam int ATTR_FLIP_X = 6;

    // Pixel as delivered to the compositor: palette select above the two
    // pattern-plane bits.
    typedef struct packed {
        logic [1:0] pal;
        logic [1:0] pix;
    } sprite_px_t;

    // Mirror a pattern byte so that the leftmost screen pixel ends up in
    // bit 7, which is the bit the shift registers present first.
    function automatic logic [7:0] reverse_byte(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_slot.sv
// ---------------------------------------------------------------------------
// sprite_slot
//
// One sprite slot: fetch latches (two pattern planes, attribute, X, sprite-
// zero tag), an X down-counter that delays the sprite to its screen column,
// and the two pattern shift registers that serialise it.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   fetch_en      sprite fetch phase active
//   fetch_slot    slot addressed by the current fetch (matched against IDX)
//   save_pat0     latch low pattern plane
//   save_pat1     latch high pattern plane, attribute, X and sprite-zero tag
//   inscan        fetched sprite valid; pattern forced to 0 otherwise
//   at_i          attribute byte (bit 6 = flip-X)
//   pat_i         pattern byte
//   x_i           sprite X coordinate
//   spr0_i        fetched sprite is OAM entry 0
//   load_sr       copy latched patterns into the shift registers
//   px_en         visible-pixel strobe
//   pix           slot pixel {p1, p0}, 0 when the slot is not active
//   opaque        slot pixel is nonzero
//   at            latched attribute byte
//   spr0          latched sprite-zero tag
// ---------------------------------------------------------------------------
module sprite_slot
    import ppu_sprite_pkg::*;
#(
    parameter int SW  = 3,
    parameter int IDX = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_en,
    input  logic [SW-1:0] fetch_slot,
    input  logic          save_pat0,
    input  logic          save_pat1,
    input  logic          inscan,
    input  logic [7:0]    at_i,
    input  logic [7:0]    pat_i,
    input  logic [7:0]    x_i,
    input  logic          spr0_i,
    input  logic          load_sr,
    input  logic          px_en,
    output logic [1:0]    pix,
    output logic          opaque,
    output logic [7:0]    at,
    output logic          spr0
);

    logic       hit;
    logic [7:0] pat_valid;
    logic [7:0] pat_store;
    logic [7:0] pat0;
    logic [7:0] pat1;
    logic [7:0] x;
    logic [7:0] xc;
    logic [7:0] sr0;
    logic [7:0] sr1;
    logic       active;

    // A fetch only lands here when the slot index matches; an out-of-range
    // fetch_slot matches no slot and so writes nothing anywhere.
    assign hit       = fetch_en && (fetch_slot == SW'(IDX));
    assign pat_valid = inscan ? pat_i : 8'h00;
    assign pat_store = at_i[ATTR_FLIP_X] ? reverse_byte(pat_valid) : pat_valid;

    // Fetch latches. Flipping is done once here so the shifters never need
    // to know about it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat0 <= 8'h00;
            pat1 <= 8'h00;
            at   <= 8'h00;
            x    <= 8'h00;
            spr0 <= 1'b0;
        end else begin
            if (hit && save_pat0) begin
                pat0 <= pat_store;
            end
            if (hit && save_pat1) begin
                pat1 <= pat_store;
                at   <= at_i;
                x    <= x_i;
                spr0 <= spr0_i;
            end
        end
    end

    // The slot becomes active once the counter has run down to zero while
    // pixels are being emitted.
    assign active = px_en && (xc == 8'd0);

    // X counter: reloaded from the latched X outside the visible region,
    // counted down one per visible pixel until the sprite column is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            xc <= 8'd0;
        end else if (!px_en) begin
            xc <= x;
        end else if (xc != 8'd0) begin
            xc <= xc - 8'd1;
        end
    end

    // Shift registers. load_sr reads the latches as they were before this
    // edge, so a save_pat1 in the same cycle is not seen until the next load.
    // Zero fill makes the slot transparent after its eighth pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr0 <= 8'h00;
            sr1 <= 8'h00;
        end else if (load_sr) begin
            sr0 <= pat0;
            sr1 <= pat1;
        end else if (active) begin
            sr0 <= {sr0[6:0], 1'b0};
            sr1 <= {sr1[6:0], 1'b0};
        end
    end

    assign pix    = active ? {sr1[7], sr0[7]} : 2'b00;
    assign opaque = (pix != 2'b00);

endmodule

// File: rtl/sprite_bank.sv
// ---------------------------------------------------------------------------
// sprite_bank
//
// NSPRITES sprite slots feeding a registered priority mux. The lowest-index
// opaque slot wins; all sprites are hidden in the leftmost 8 columns when
// clip_left is set; slot 0 additionally reports sprite-zero opacity for the
// sprite-zero-hit logic downstream.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   fetch_en        sprite fetch phase active
//   fetch_slot      slot targeted by the current fetch
//   save_pat0       latch low pattern plane into the targeted slot
//   save_pat1       latch high plane, attribute, X, sprite-zero tag
//   inscan          fetched sprite valid; pattern forced to 0 otherwise
//   at_i            attribute byte: [1:0] palette, [5] priority, [6] flip-X
//   pat_i           pattern byte from CHR
//   x_i             sprite X coordinate
//   spr0_i          fetched sprite is OAM entry 0
//   load_sr         copy latched patterns into all shift registers
//   px_en           visible-pixel strobe
//   px_x            screen X of the current pixel
//   clip_left       hide sprites for px_x < 8
//   px_o            winning pixel {palette, p1, p0}, registered
//   pri_o           winner's priority bit (1 = behind background), registered
//   spr0_opaque_o   sprite-zero slot opaque at this pixel, registered
// ---------------------------------------------------------------------------
module sprite_bank
    import ppu_sprite_pkg::*;
#(
    parameter  int NSPRITES = 8,
    localparam int SW       = (NSPRITES > 1) ? $clog2(NSPRITES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_en,
    input  logic [SW-1:0] fetch_slot,
    input  logic          save_pat0,
    input  logic          save_pat1,
    input  logic          inscan,
    input  logic [7:0]    at_i,
    input  logic [7:0]    pat_i,
    input  logic [7:0]    x_i,
    input  logic          spr0_i,
    input  logic          load_sr,
    input  logic          px_en,
    input  logic [7:0]    px_x,
    input  logic          clip_left,
    output logic [3:0]    px_o,
    output logic          pri_o,
    output logic          spr0_opaque_o
);

    logic [1:0] slot_pix    [NSPRITES];
    logic       slot_opaque [NSPRITES];
    logic [7:0] slot_at     [NSPRITES];
    logic       slot_spr0   [NSPRITES];

    sprite_px_t win_px;
    logic       win_pri;
    logic       spr0_next;
    logic       clipped;
    logic       unused_bits;

    // One slot per sprite; each compares fetch_slot against its own index.
    for (genvar s = 0; s < NSPRITES; s++) begin : g_slot
        sprite_slot #(
            .SW  (SW),
            .IDX (s)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .fetch_en   (fetch_en),
            .fetch_slot (fetch_slot),
            .save_pat0  (save_pat0),
            .save_pat1  (save_pat1),
            .inscan     (inscan),
            .at_i       (at_i),
            .pat_i      (pat_i),
            .x_i        (x_i),
            .spr0_i     (spr0_i),
            .load_sr    (load_sr),
            .px_en      (px_en),
            .pix        (slot_pix[s]),
            .opaque     (slot_opaque[s]),
            .at         (slot_at[s]),
            .spr0       (slot_spr0[s])
        );
    end

    assign clipped = clip_left && (px_x < 8'd8);

    // Priority mux. Scanning from the highest index down lets each lower
    // opaque slot overwrite the result, so the lowest index ends up winning.
    always_comb begin
        win_px  = '0;
        win_pri = 1'b0;
        for (int s = NSPRITES - 1; s >= 0; s--) begin
            if (slot_opaque[s] && !clipped) begin
                win_px.pal = slot_at[s][ATTR_PAL_LO +: 2];
                win_px.pix = slot_pix[s];
                win_pri    = slot_at[s][ATTR_PRI];
            end
        end
    end

    // Only slot 0 can hold sprite zero, so the tag in other slots is ignored.
    assign spr0_next = slot_spr0[0] && slot_opaque[0] && !clipped;

    // Attribute bits and sprite-zero tags that the mux never looks at.
    always_comb begin
        unused_bits = 1'b0;
        for (int s = 0; s < NSPRITES; s++) begin
            unused_bits = unused_bits ^ (^{slot_at[s][7:6], slot_at[s][4:2], slot_spr0[s]});
        end
    end

    // Output registers: they carry the previous pixel cycle's result and
    // drop to transparent after any cycle without a pixel strobe.
    always_ff @(posedge clk) begin
        if (rst || !px_en) begin
            px_o          <= 4'h0;
            pri_o         <= 1'b0;
            spr0_opaque_o <= 1'b0;
        end else begin
            px_o          <= win_px;
            pri_o         <= win_pri;
            spr0_opaque_o <= spr0_next;
        end
    end

endmodule

// File: tb/tb_sprite_bank.sv
// ---------------------------------------------------------------------------
// tb_sprite_bank
//
// Self-checking bench for sprite_bank built with 12 slots (4-bit slot index,
// so fetch_slot values 12..15 are out of range). Expected pixels come from a
// per-line model: a sprite at X shows pattern bit (7 - (n - X)) on the n-th
// visible pixel of the line, for n - X in 0..7.
// ---------------------------------------------------------------------------
module tb_sprite_bank;

    localparam int NS = 12;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_en;
    logic [SW-1:0] fetch_slot;
    logic          save_pat0;
    logic          save_pat1;
    logic          inscan;
    logic [7:0]    at_i;
    logic [7:0]    pat_i;
    logic [7:0]    x_i;
    logic          spr0_i;
    logic          load_sr;
    logic          px_en;
    logic [7:0]    px_x;
    logic          clip_left;
    logic [3:0]    px_o;
    logic          pri_o;
    logic          spr0_opaque_o;

    int assertCount = 0;
    int failCount   = 0;

    // Reference state: what each slot has latched, and what its shifters
    // were loaded with at the most recent load_sr.
    logic [7:0] m_pat0 [NS];
    logic [7:0] m_pat1 [NS];
    logic [7:0] m_at   [NS];
    logic [7:0] m_x    [NS];
    logic       m_spr0 [NS];
    logic [7:0] m_sr0  [NS];
    logic [7:0] m_sr1  [NS];

    sprite_bank #(.NSPRITES(NS)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .fetch_slot    (fetch_slot),
        .save_pat0     (save_pat0),
        .save_pat1     (save_pat1),
        .inscan        (inscan),
        .at_i          (at_i),
        .pat_i         (pat_i),
        .x_i           (x_i),
        .spr0_i        (spr0_i),
        .load_sr       (load_sr),
        .px_en         (px_en),
        .px_x          (px_x),
        .clip_left     (clip_left),
        .px_o          (px_o),
        .pri_o         (pri_o),
        .spr0_opaque_o (spr0_opaque_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] mirror(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7 - i];
        return r;
    endfunction

    task automatic clearModel();
        for (int s = 0; s < NS; s++) begin
            m_pat0[s] = 8'h00; m_pat1[s] = 8'h00; m_at[s] = 8'h00;
            m_x[s] = 8'h00; m_spr0[s] = 1'b0; m_sr0[s] = 8'h00; m_sr1[s] = 8'h00;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] ep,
                               input logic epri, input logic es0);
        assertCount++;
        assert (px_o === ep) else begin
            failCount++;
            $error("[TB] FAIL %s px_o: got %h expected %h", tag, px_o, ep);
        end
        assertCount++;
        assert (pri_o === epri) else begin
            failCount++;
            $error("[TB] FAIL %s pri_o: got %b expected %b", tag, pri_o, epri);
        end
        assertCount++;
        assert (spr0_opaque_o === es0) else begin
            failCount++;
            $error("[TB] FAIL %s spr0_opaque_o: got %b expected %b", tag, spr0_opaque_o, es0);
        end
    endtask

    // Expected registered outputs for the n-th visible pixel of the line.
    function automatic void expectAt(input int n, input bit clip, output logic [3:0] ep,
                                     output logic epri, output logic es0);
        bit         found;
        int         k;
        logic [1:0] p;
        ep = 4'h0; epri = 1'b0; es0 = 1'b0; found = 0;
        for (int s = 0; s < NS; s++) begin
            k = n - int'(m_x[s]);
            p = 2'b00;
            if (k >= 0 && k < 8) p = {m_sr1[s][7 - k], m_sr0[s][7 - k]};
            if (clip && n < 8) p = 2'b00;
            if (s == 0) es0 = m_spr0[0] && (p != 2'b00);
            if (!found && p != 2'b00) begin
                found = 1;
                ep    = {m_at[s][1:0], p};
                epri  = m_at[s][5];
            end
        end
    endfunction

    task automatic doReset();
        rst = 1'b1; px_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clearModel();
        checkOutput("reset", 4'h0, 1'b0, 1'b0);
    endtask

    // Two-cycle fetch of one sprite into a slot; optionally pulse load_sr
    // together with save_pat1.
    task automatic applyStimulus(input int slot, input logic [7:0] p0, input logic [7:0] p1,
                                 input logic [7:0] at, input logic [7:0] x,
                                 input logic spr0, input logic insc, input bit withLoad);
        logic [7:0] v0, v1;
        v0 = insc ? p0 : 8'h00;
        v1 = insc ? p1 : 8'h00;
        if (at[6]) begin v0 = mirror(v0); v1 = mirror(v1); end
        px_en = 1'b0; fetch_en = 1'b1; fetch_slot = SW'(slot);
        inscan = insc; at_i = at; x_i = x; spr0_i = spr0;
        pat_i = p0; save_pat0 = 1'b1;
        tick();
        save_pat0 = 1'b0;
        if (slot < NS) m_pat0[slot] = v0;
        pat_i = p1; save_pat1 = 1'b1; load_sr = withLoad;
        tick();
        save_pat1 = 1'b0; load_sr = 1'b0; fetch_en = 1'b0;
        if (withLoad) begin
            for (int s = 0; s < NS; s++) begin
                m_sr0[s] = m_pat0[s]; m_sr1[s] = m_pat1[s];
            end
        end
        if (slot < NS) begin
            m_pat1[slot] = v1; m_at[slot] = at; m_x[slot] = x; m_spr0[slot] = spr0;
        end
    endtask

    task automatic loadLine();
        px_en = 1'b0; load_sr = 1'b1;
        tick();
        load_sr = 1'b0;
        for (int s = 0; s < NS; s++) begin
            m_sr0[s] = m_pat0[s]; m_sr1[s] = m_pat1[s];
        end
    endtask

    task automatic stepPixel(input string name, input int n, input bit clip);
        logic [3:0] ep;
        logic       epri, es0;
        px_en = 1'b1; px_x = 8'(n); clip_left = clip;
        tick();
        expectAt(n, clip, ep, epri, es0);
        checkOutput($sformatf("%s n=%0d", name, n), ep, epri, es0);
    endtask

    task automatic endLine(input string name);
        px_en = 1'b0; px_x = 8'h00;
        tick();
        checkOutput($sformatf("%s idle", name), 4'h0, 1'b0, 1'b0);
    endtask

    task automatic runLine(input string name, input int len, input bit clip);
        for (int n = 0; n < len; n++) stepPixel(name, n, clip);
        endLine(name);
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; fetch_slot = '0; save_pat0 = 1'b0; save_pat1 = 1'b0;
        inscan = 1'b0; at_i = 8'h00; pat_i = 8'h00; x_i = 8'h00; spr0_i = 1'b0;
        load_sr = 1'b0; px_en = 1'b0; px_x = 8'h00; clip_left = 1'b0;
        clearModel();

        // Single opaque pixel at x=3: px_o=5 only on the cycle after px_x=3.
        doReset();
        applyStimulus(0, 8'h80, 8'h00, 8'h01, 8'd3, 1'b0, 1'b1, 0);
        loadLine();
        runLine("basic", 16, 0);

        // Flip-X: pattern 01 mirrors to 80 on both planes.
        doReset();
        applyStimulus(0, 8'h01, 8'h01, 8'h40, 8'd0, 1'b0, 1'b1, 0);
        loadLine();
        runLine("flip", 12, 0);

        // Overlap: slot 2 beats slot 5; then blank slot 2 and slot 5 shows.
        doReset();
        applyStimulus(2, 8'hFF, 8'h00, 8'h20, 8'd10, 1'b0, 1'b1, 0);
        applyStimulus(5, 8'h00, 8'hFF, 8'h03, 8'd10, 1'b0, 1'b1, 0);
        loadLine();
        runLine("prio", 22, 0);
        applyStimulus(2, 8'hFF, 8'hFF, 8'h20, 8'd10, 1'b0, 1'b0, 0);
        loadLine();
        runLine("prio_blank", 22, 0);

        // Sprite zero with and without left clipping.
        doReset();
        applyStimulus(0, 8'hFF, 8'h00, 8'h00, 8'd4, 1'b1, 1'b1, 0);
        loadLine();
        runLine("spr0_clip", 16, 1);
        loadLine();
        runLine("spr0_noclip", 16, 0);

        // Out-of-scan fetch stays transparent; out-of-range slot writes nothing.
        doReset();
        applyStimulus(3, 8'hFF, 8'hFF, 8'h03, 8'd2, 1'b0, 1'b0, 0);
        applyStimulus(13, 8'hFF, 8'hFF, 8'h02, 8'd0, 1'b1, 1'b1, 0);
        loadLine();
        runLine("inscan0", 16, 0);

        // save_pat1 together with load_sr: shifters get the old high plane.
        doReset();
        applyStimulus(0, 8'hF0, 8'hF0, 8'h01, 8'd0, 1'b0, 1'b1, 0);
        applyStimulus(0, 8'h0F, 8'h0F, 8'h02, 8'd0, 1'b0, 1'b1, 1);
        runLine("simul", 12, 0);

        // Highest slot alone, then reset mid-line.
        doReset();
        applyStimulus(NS - 1, 8'hAA, 8'h55, 8'h02, 8'd0, 1'b0, 1'b1, 0);
        loadLine();
        for (int n = 0; n < 4; n++) stepPixel("last", n, 0);
        rst = 1'b1; px_en = 1'b1; px_x = 8'd4;
        tick();
        rst = 1'b0;
        clearModel();
        checkOutput("rst_midline", 4'h0, 1'b0, 1'b0);
        for (int n = 5; n < 14; n++) stepPixel("after_rst", n, 0);
        endLine("after_rst");
        loadLine();
        runLine("after_rst_load", 10, 0);
        applyStimulus(NS - 1, 8'hAA, 8'h55, 8'h02, 8'd0, 1'b0, 1'b1, 0);
        loadLine();
        runLine("reloaded", 10, 0);

        // Randomised lines; slot state carries over between lines.
        doReset();
        for (int line = 0; line < 24; line++) begin
            int nf;
            nf = $urandom_range(1, 4);
            for (int f = 0; f < nf; f++) begin
                applyStimulus($urandom_range(0, 15), 8'($urandom), 8'($urandom), 8'($urandom),
                              8'($urandom_range(0, 24)), 1'($urandom),
                              ($urandom_range(0, 4) != 0), 0);
            end
            loadLine();
            runLine($sformatf("rand%0d", line), 36, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
